instruction_fetch_mem: RTL

INSTRUCTION_FETCH_MEM -- requirements
Module: instruction_fetch_mem

---
 rtl/instruction_fetch_mem.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/instruction_fetch_mem.sv
// Instruction memory with a fixed-latency fetch pipeline.
// Fills itself with NOP_WORD after reset, then serves fetches and program writes.
module instruction_fetch_mem #(
    parameter int          DEPTH    = 64,
    parameter int          LATENCY  = 1,
    parameter logic [31:0] NOP_WORD = 32'hE000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_err,
    input  logic        resp_ready,
    input  logic        flush,
    input  logic        prog_we,
    input  logic [31:0] prog_addr,
    input  logic [31:0] prog_data,
    output logic        init_done
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] sweep_q, sweep_d;

    logic [31:0] mem_q [DEPTH];

    logic          run;
    logic          advance;
    logic          accept;
    logic [AW-1:0] req_idx;
    logic          req_bad;
    logic [31:0]   req_word;
    logic [AW-1:0] prog_idx;
    logic          prog_bad;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;

    logic        v_q    [LATENCY];
    logic [31:0] data_q [LATENCY];
    logic        err_q  [LATENCY];

    // Fill-sweep / run state machine
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_INIT;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        unique case (state_q)
            S_INIT: begin
                sweep_d = sweep_q + 1'b1;
                if (sweep_q == LAST_IDX) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                state_d = S_RUN;
            end
        endcase
    end

    assign run       = (state_q == S_RUN);
    assign init_done = run;

    assign req_idx  = req_addr[AW+1:2];
    assign req_bad  = (|req_addr[1:0]) | (|req_addr[31:AW+2]);
    assign req_word = req_bad ? NOP_WORD : mem_q[req_idx];

    assign prog_idx = prog_addr[AW+1:2];
    assign prog_bad = (|prog_addr[1:0]) | (|prog_addr[31:AW+2]);

    // Sweep owns the write port in INIT; bad program writes are dropped
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = sweep_q;
        mem_wdata = NOP_WORD;
        if (!rst) begin
            if (!run) begin
                mem_we = 1'b1;
            end else if (prog_we && !prog_bad) begin
                mem_we    = 1'b1;
                mem_waddr = prog_idx;
                mem_wdata = prog_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign resp_valid = v_q[LATENCY-1];
    assign resp_data  = data_q[LATENCY-1];
    assign resp_err   = err_q[LATENCY-1];

    assign advance   = !(resp_valid && !resp_ready);
    assign req_ready = run && advance && !prog_we && !flush && !rst;
    assign accept    = req_valid && req_ready;

    // Data is captured at accept, so later program writes cannot disturb it
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                v_q[i]    <= 1'b0;
                data_q[i] <= NOP_WORD;
                err_q[i]  <= 1'b0;
            end
        end else if (flush) begin
            for (int i = 0; i < LATENCY; i++) begin
                v_q[i] <= 1'b0;
            end
        end else if (advance) begin
            v_q[0]    <= accept;
            data_q[0] <= accept ? req_word : NOP_WORD;
            err_q[0]  <= accept && req_bad;
            for (int i = LATENCY - 1; i > 0; i--) begin
                v_q[i]    <= v_q[i-1];
                data_q[i] <= data_q[i-1];
                err_q[i]  <= err_q[i-1];
            end
        end
    end

endmodule
